// File: rtl/alu_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sched_pkg : shared types and constants for the ALU scheduler     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 8;

  // Bit order of the result is {shift, cmp, logic, arith}.
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    return 4'b0001 << unit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sched_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter with a registered pointer      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       pointer
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // After a grant, priority passes to the requester that was not served.
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) ptr_d = ~grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign pointer = ptr_q;

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sched : arbitrates two requesters onto an external ALU datapath  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [3:0]       REQ0_FUN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [3:0]       REQ1_FUN,
  output logic             RSP0_VALID,
  input  logic             RSP0_READY,
  output logic             RSP1_VALID,
  input  logic             RSP1_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_FUN,
  output logic             ARITH_EN,
  output logic             LOGIC_EN,
  output logic             CMP_EN,
  output logic             SHIFT_EN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_FLAG
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]       fun_q, fun_d;
  logic             gnt_q, gnt_d, err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [1:0] req_valid, grant;
  logic       ptr, accept, win_idx, rsp_take;
  logic [3:0] en;

  assign req_valid = {REQ1_VALID, REQ0_VALID};

  // Gating valid with IDLE keeps every READY low in the other states.
  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .valid   (req_valid & {2{state_q == ST_IDLE}}),
    .advance (accept),
    .grant   (grant),
    .pointer (ptr)
  );

  assign accept   = |grant;
  assign win_idx  = (&req_valid) ? ptr : req_valid[1];
  assign rsp_take = gnt_q ? RSP1_READY : RSP0_READY;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = win_idx ? REQ1_A   : REQ0_A;
          b_d     = win_idx ? REQ1_B   : REQ0_B;
          fun_d   = win_idx ? REQ1_FUN : REQ0_FUN;
          gnt_d   = win_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ALU_FLAG) begin
          data_d  = ALU_OUT;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= 4'd0;
      gnt_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en = (state_q == ST_ISSUE) ? unit_onehot(fun_q[3:2]) : 4'b0000;
  assign {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN} = en;

  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];
  assign RSP0_VALID = (state_q == ST_RESP) && !gnt_q;
  assign RSP1_VALID = (state_q == ST_RESP) &&  gnt_q;
  assign RSP_DATA   = data_q;
  assign RSP_ERR    = err_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign ALU_FUN    = fun_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_alu_sched : scoreboard bench with a variable-latency ALU model    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_sched;

  localparam int W  = 16;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [W-1:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]    REQ0_FUN, REQ1_FUN;
  logic          RSP0_VALID, RSP1_VALID, RSP0_READY, RSP1_READY;
  logic [W-1:0]  RSP_DATA, ALU_A, ALU_B, ALU_OUT;
  logic          RSP_ERR, ALU_FLAG;
  logic [1:0]    ALU_FUN;
  logic          ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;

  alu_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
    .ALU_OUT(ALU_OUT), .ALU_FLAG(ALU_FLAG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e, h;
  int          total = 0, bad = 0;
  int          cyc = 0, acc_cyc = 0, last_hs = 0, lat = 1, ai;
  logic        busy = 0, ptr_m = 0, chk_on = 0, b2b = 0, b2b_armed = 0, stray = 0;
  logic        seen = 0, hold_prev = 0;
  logic [15:0] prev_data, cur_a, cur_b;
  logic [3:0]  cur_fun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference datapath: the function codes this bench's ALU implements.
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a + 16'd1;
      4'b0011: return a - 16'd1;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~a;
      4'b1000: return (a < b) ? 16'd1 : 16'd0;
      4'b1001: return (a == b) ? 16'd1 : 16'd0;
      4'b1010: return (a < b) ? a : b;
      4'b1011: return ($signed(a) < $signed(b)) ? a : b;
      4'b1100: return a << b[3:0];
      4'b1101: return a >> b[3:0];
      4'b1110: return 16'($signed(a) >>> b[3:0]);
      default: return (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
    endcase
  endfunction

  function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // ALU model: result and flag appear lat cycles after the enable; lat 0 never answers.
  logic [15:0] alu_out_r, res_r;
  logic        flag_r = 0;
  int          cnt_m = 0;
  logic [3:0]  en_v;
  logic [1:0]  unit_v;
  assign en_v     = {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN};
  assign unit_v   = {SHIFT_EN | CMP_EN, SHIFT_EN | LOGIC_EN};
  assign ALU_OUT  = alu_out_r;
  assign ALU_FLAG = flag_r | stray;

  always @(posedge CLK) begin
    flag_r    <= 1'b0;
    alu_out_r <= 16'($urandom);
    if (RST) cnt_m <= 0;
    else if (en_v != 4'b0000) begin
      if (lat == 1) begin
        flag_r    <= 1'b1;
        alu_out_r <= alu_ref({unit_v, ALU_FUN}, ALU_A, ALU_B);
      end else begin
        cnt_m <= (lat == 0) ? 0 : lat - 1;
        res_r <= alu_ref({unit_v, ALU_FUN}, ALU_A, ALU_B);
      end
    end else if (cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin
        flag_r    <= 1'b1;
        alu_out_r <= res_r;
      end
    end
  end

  // Edge monitor: handshakes, accepts, scoreboard push.
  always @(posedge CLK) begin
    if (RST) begin
      sb.delete();
      busy      = 0;
      ptr_m     = 0;
      b2b_armed = 0;
    end else begin
      if (busy && ((RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY))) begin
        busy    = 0;
        last_hs = cyc;
      end
      if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) begin
        ai      = (REQ1_VALID && REQ1_READY) ? 1 : 0;
        cur_a   = ai ? REQ1_A : REQ0_A;
        cur_b   = ai ? REQ1_B : REQ0_B;
        cur_fun = ai ? REQ1_FUN : REQ0_FUN;
        e.idx   = ai;
        e.err   = (lat == 0) || (lat > TO);
        e.data  = e.err ? 16'd0 : alu_ref(cur_fun, cur_a, cur_b);
        e.lat   = e.err ? TO + 2 : lat + 2;
        sb.push_back(e);
        if (b2b && b2b_armed) check("b2b_gap", cyc - last_hs, 1);
        b2b_armed = b2b;
        acc_cyc   = cyc;
        busy      = 1;
        ptr_m     = (ai == 0);
      end
    end
    cyc++;
  end

  // Mid-cycle checker: ready/arbitration, enables, responses.
  always @(negedge CLK) begin
    if (!RST && chk_on) begin
      check("ready", {REQ1_READY, REQ0_READY}, busy ? 2'b00 : winner({REQ1_VALID, REQ0_VALID}, ptr_m));
      if (busy && cyc == acc_cyc + 1) begin
        check("issue_en", en_v, 4'b0001 << cur_fun[3:2]);
        check("issue_ab", {ALU_A, ALU_B}, {cur_a, cur_b});
        check("issue_fun", ALU_FUN, cur_fun[1:0]);
      end else begin
        check("en_off", en_v, 4'b0000);
      end
      if (!busy) begin
        check("rsp_idle", {RSP1_VALID, RSP0_VALID}, 2'b00);
      end else if (RSP0_VALID || RSP1_VALID) begin
        if (sb.size() != 1) begin
          check("sb_size", sb.size(), 1);
        end else begin
          h = sb[0];
          check("rsp_valid", {RSP1_VALID, RSP0_VALID}, 2'b01 << h.idx);
          check("rsp_data", RSP_DATA, h.data);
          check("rsp_err", RSP_ERR, h.err);
          if (hold_prev) check("hold_data", RSP_DATA, prev_data);
          if (!seen) check("latency", cyc - acc_cyc, h.lat);
          seen      = 1;
          prev_data = RSP_DATA;
          hold_prev = 1;
          if ((RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY)) begin
            void'(sb.pop_front());
            seen      = 0;
            hold_prev = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    if (idx == 0) begin REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_FUN = f; end
    else          begin REQ1_VALID = 1; REQ1_A = a; REQ1_B = b; REQ1_FUN = f; end
  endtask

  task automatic wait_acc(input int idx);
    logic rdy;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      rdy = (idx == 0) ? REQ0_READY : REQ1_READY;
      if (rdy) begin
        @(posedge CLK);
        #1;
        if (idx == 0) REQ0_VALID = 0; else REQ1_VALID = 0;
        return;
      end
    end
    check("accept_timeout", rdy, 1'b1);
    if (idx == 0) REQ0_VALID = 0; else REQ1_VALID = 0;
  endtask

  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    set_req(idx, a, b, f);
    wait_acc(idx);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy) begin step(); return; end
    end
    check("idle_timeout", busy, 1'b0);
    step();
  endtask

  task automatic zero_chk(input string tag);
    @(negedge CLK);
    check({tag, "_data"}, {RSP_ERR, RSP_DATA}, 17'd0);
    check({tag, "_alu"}, {ALU_A, ALU_B}, 32'd0);
    check({tag, "_ctl"}, {REQ1_READY, REQ0_READY, RSP1_VALID, RSP0_VALID, ALU_FUN, en_v}, 10'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; REQ0_VALID = 0; REQ1_VALID = 0;
    REQ0_A = 0; REQ0_B = 0; REQ0_FUN = 0; REQ1_A = 0; REQ1_B = 0; REQ1_FUN = 0;
    RSP0_READY = 1; RSP1_READY = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    chk_on = 1;
    zero_chk("reset");

    // Both valid at the first IDLE: requester 0 has priority, then 1.
    step();
    lat = 1;
    set_req(0, 16'd3, 16'd7, 4'b1011);
    set_req(1, 16'd9, 16'd2, 4'b1010);
    wait_acc(0);
    wait_acc(1);
    wait_idle();

    send(0, 16'd5, 16'd5, 4'b1001);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      lat = 1 + (i % 3);
      send(i % 2, 16'($urandom), 16'($urandom), i[3:0]);
      wait_idle();
    end

    // Contention with the pointer on requester 1.
    send(0, 16'h1234, 16'h0F0F, 4'b0100);
    wait_idle();
    set_req(0, 16'h00FF, 16'h0003, 4'b1100);
    set_req(1, 16'h8000, 16'h0004, 4'b1110);
    wait_acc(1);
    wait_acc(0);
    wait_idle();

    // Timeout boundaries: never, one too late, exactly on the last cycle.
    lat = 0; send(1, 16'd11, 16'd22, 4'b0000); wait_idle();
    lat = 9; send(0, 16'd11, 16'd22, 4'b0001); wait_idle();
    lat = 8; send(1, 16'd40, 16'd2,  4'b0000); wait_idle();

    // Requester 1 stalls its response while requester 0 waits.
    lat = 1;
    RSP1_READY = 0;
    send(1, 16'hABCD, 16'h00F0, 4'b0101);
    for (int i = 0; i < 50 && !RSP1_VALID; i++) @(negedge CLK);
    step();
    set_req(0, 16'd100, 16'd1, 4'b0001);
    repeat (2) step();
    stray = 1; step(); stray = 0;
    repeat (2) step();
    RSP1_READY = 1;
    wait_acc(0);
    wait_idle();

    // Stray flags with nothing outstanding.
    stray = 1; repeat (2) step(); stray = 0;
    repeat (2) step();

    // Reset in WAIT abandons the operation.
    lat = 0;
    send(0, 16'd7, 16'd8, 4'b0000);
    repeat (3) step();
    RST = 1; step(); RST = 0;
    zero_chk("midrst");
    repeat (3) step();
    lat = 1;
    send(1, 16'd6, 16'd6, 4'b0110);
    wait_idle();

    // Back-to-back requests from requester 0 alone.
    b2b = 1;
    for (int i = 0; i < 4; i++) send(0, 16'(i * 3), 16'd1, 4'b0000);
    wait_idle();
    b2b = 0;

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
